// File: rtl/gptim_mc_if.sv
// Peripheral bus bundle for the gptim_mc timer block: byte-addressed
// register reads and writes with byte strobes and a registered read port.
interface gptim_mc_if #(
    parameter int ADDR_WIDTH = 5
) ();
    logic [ADDR_WIDTH-1:0] addr;
    logic                  rd_en;
    logic                  wr_en;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strobe;
    logic [31:0]           rd_data;

    modport master (
        output addr, rd_en, wr_en, wr_data, wr_strobe,
        input  rd_data
    );

    modport slave (
        input  addr, rd_en, wr_en, wr_data, wr_strobe,
        output rd_data
    );
endinterface

// File: rtl/gptim_mc.sv
// Multi-channel general-purpose timer: per-channel prescaler, auto-reload,
// continuous or one-shot mode and a write-1-to-clear interrupt flag.
module gptim_mc #(
    parameter int CHANNELS    = 2,
    parameter int WIDTH       = 32,
    parameter int PRESC_WIDTH = 16,
    parameter int ADDR_WIDTH  = (4 + $clog2(CHANNELS) < 4) ? 4 : 4 + $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    gptim_mc_if.slave           bus,
    output logic [CHANNELS-1:0] irq
);

    function automatic logic [31:0] byte_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{strb[b]}};
        return m;
    endfunction

    logic [ADDR_WIDTH-1:0] win;
    logic [1:0]            off;
    logic                  chan_ok;
    logic [31:0]           wmask;
    logic [31:0]           rd_word [CHANNELS][4];
    logic [31:0]           rd_next;

    // Each channel owns a 16-byte window; win is the window index.
    assign win     = bus.addr >> 4;
    assign off     = bus.addr[3:2];
    assign chan_ok = win < ADDR_WIDTH'(CHANNELS);
    assign wmask   = byte_mask(bus.wr_strobe);

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        logic                   en, oneshot, ie, iflag;
        logic [PRESC_WIDTH-1:0] psc, psc_cnt;
        logic [WIDTH-1:0]       arr, cnt;
        logic                   sel, wr_ctrl, wr_psc, wr_arr, wr_cnt;
        logic                   ctrl_lo, if_clr, tick, overflow;

        assign sel      = bus.wr_en && chan_ok && (win == ADDR_WIDTH'(n));
        assign wr_ctrl  = sel && (off == 2'd0);
        assign wr_psc   = sel && (off == 2'd1);
        assign wr_arr   = sel && (off == 2'd2);
        assign wr_cnt   = sel && (off == 2'd3);
        assign ctrl_lo  = wr_ctrl && bus.wr_strobe[0];
        assign if_clr   = wr_ctrl && bus.wr_strobe[1] && bus.wr_data[8];
        assign tick     = en && (psc_cnt == psc);
        // A software CNT write in the same cycle swallows the tick entirely.
        assign overflow = tick && (cnt == arr) && !wr_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                en      <= 1'b0;
                oneshot <= 1'b0;
                ie      <= 1'b0;
                iflag   <= 1'b0;
                psc     <= '0;
                arr     <= '0;
                cnt     <= '0;
                psc_cnt <= '0;
            end else begin
                if (ctrl_lo) begin
                    en      <= bus.wr_data[0];
                    oneshot <= bus.wr_data[1];
                    ie      <= bus.wr_data[2];
                end else if (overflow && oneshot) begin
                    en <= 1'b0;
                end

                if (overflow)    iflag <= 1'b1;
                else if (if_clr) iflag <= 1'b0;

                if (wr_psc)
                    psc <= (psc & ~wmask[PRESC_WIDTH-1:0])
                         | (bus.wr_data[PRESC_WIDTH-1:0] & wmask[PRESC_WIDTH-1:0]);
                if (wr_arr)
                    arr <= (arr & ~wmask[WIDTH-1:0]) | (bus.wr_data[WIDTH-1:0] & wmask[WIDTH-1:0]);

                // Past-ARR counts wrap modulo 2^WIDTH without raising IF.
                if (wr_cnt)
                    cnt <= (cnt & ~wmask[WIDTH-1:0]) | (bus.wr_data[WIDTH-1:0] & wmask[WIDTH-1:0]);
                else if (tick)
                    cnt <= (cnt == arr) ? '0 : cnt + WIDTH'(1);

                if (wr_psc || (ctrl_lo && !bus.wr_data[0]))
                    psc_cnt <= '0;
                else if (en)
                    psc_cnt <= tick ? '0 : psc_cnt + PRESC_WIDTH'(1);
            end
        end

        assign irq[n]        = iflag & ie;
        assign rd_word[n][0] = {23'd0, iflag, 5'd0, ie, oneshot, en};
        assign rd_word[n][1] = 32'(psc);
        assign rd_word[n][2] = 32'(arr);
        assign rd_word[n][3] = 32'(cnt);
    end

    always_comb begin
        rd_next = '0;
        for (int n = 0; n < CHANNELS; n++)
            if (chan_ok && (win == ADDR_WIDTH'(n))) rd_next = rd_word[n][off];
    end

    // Reads sample register state before any same-cycle write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          bus.rd_data <= '0;
        else if (bus.rd_en)  bus.rd_data <= rd_next;
    end

endmodule

// File: tb/tb_gptim_mc.sv
// Self-checking bench for gptim_mc: directed vector table, multi-cycle corner
// sequences and randomized traffic against a behavioural register model.
module tb_gptim_mc;
    localparam int CH = 3;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] irq;

    gptim_mc_if #(.ADDR_WIDTH(AW)) bus ();

    gptim_mc #(.CHANNELS(CH), .WIDTH(8), .PRESC_WIDTH(4), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Behavioural model state.
    bit          m_en [CH], m_os [CH], m_ie [CH], m_if [CH];
    int unsigned m_psc[CH], m_arr[CH], m_cnt[CH], m_pc[CH];
    logic [31:0] m_rd;

    typedef struct {
        logic [5:0]  addr;
        bit          rd;
        bit          wr;
        logic [31:0] data;
        logic [3:0]  strb;
        bit          chk;
        logic [31:0] exp_rd;
        logic [2:0]  exp_irq;
    } vec_t;
    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%h required=0x%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int c = 0; c < CH; c++) begin
            m_en[c] = 0; m_os[c] = 0; m_ie[c] = 0; m_if[c] = 0;
            m_psc[c] = 0; m_arr[c] = 0; m_cnt[c] = 0; m_pc[c] = 0;
        end
        m_rd = 0;
    endfunction

    function automatic logic [31:0] m_read(input int a);
        int c = a / 16;
        int o = (a % 16) / 4;
        if (c >= CH) return 0;
        case (o)
            0:       return 256 * m_if[c] + 4 * m_ie[c] + 2 * m_os[c] + m_en[c];
            1:       return m_psc[c];
            2:       return m_arr[c];
            default: return m_cnt[c];
        endcase
    endfunction

    function automatic logic [2:0] m_irq();
        logic [2:0] r;
        for (int c = 0; c < CH; c++) r[c] = m_if[c] & m_ie[c];
        return r;
    endfunction

    // Applies the register-level rules for one clock edge.
    function automatic void model_step(input int a, input bit rd, input bit wr,
                                       input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) mask[8*b +: 8] = s[b] ? 8'hFF : 8'h00;
        if (rd) m_rd = m_read(a);
        for (int c = 0; c < CH; c++) begin
            bit hit_w  = wr && (a / 16 == c);
            int o      = (a % 16) / 4;
            bit tick   = m_en[c] && (m_pc[c] == m_psc[c]);
            bit wcnt   = hit_w && o == 3;
            bit ovf    = tick && (m_cnt[c] == m_arr[c]) && !wcnt;
            bit en_wr  = hit_w && o == 0 && s[0];
            bit old_en = m_en[c];
            if (wcnt)      m_cnt[c] = ((m_cnt[c] & ~mask) | (d & mask)) % 256;
            else if (tick) m_cnt[c] = (m_cnt[c] == m_arr[c]) ? 0 : (m_cnt[c] + 1) % 256;
            if ((hit_w && o == 1) || (en_wr && !d[0])) m_pc[c] = 0;
            else if (old_en) m_pc[c] = tick ? 0 : m_pc[c] + 1;
            if (en_wr) begin
                m_en[c] = d[0]; m_os[c] = d[1]; m_ie[c] = d[2];
            end else if (ovf && m_os[c]) begin
                m_en[c] = 0;
            end
            if (ovf) m_if[c] = 1;
            else if (hit_w && o == 0 && s[1] && d[8]) m_if[c] = 0;
            if (hit_w && o == 1) m_psc[c] = ((m_psc[c] & ~mask) | (d & mask)) % 16;
            if (hit_w && o == 2) m_arr[c] = ((m_arr[c] & ~mask) | (d & mask)) % 256;
        end
    endfunction

    task automatic do_cycle(input logic [5:0] a, input bit rd, input bit wr,
                            input logic [31:0] d, input logic [3:0] s);
        bus.addr = a; bus.rd_en = rd; bus.wr_en = wr; bus.wr_data = d; bus.wr_strobe = s;
        @(posedge clk);
        model_step(a, rd, wr, d, s);
        #1;
        bus.rd_en = 0; bus.wr_en = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0);
    endtask

    function automatic void addv(input logic [5:0] a, input bit rd, input bit wr, input logic [31:0] d,
                                 input logic [3:0] s, input bit chk, input logic [31:0] er, input logic [2:0] ei);
        vec_t v;
        v.addr = a; v.rd = rd; v.wr = wr; v.data = d; v.strb = s;
        v.chk = chk; v.exp_rd = er; v.exp_irq = ei;
        vq.push_back(v);
    endfunction

    initial begin
        // Reset reads over every window, including past the last channel.
        for (int i = 0; i < 16; i++) addv(6'(4 * i), 1, 0, 0, 0, 1, 0, 0);
        // Register width trimming, strobes and out-of-range window on channel 2.
        addv(6'h28, 0, 1, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        addv(6'h24, 0, 1, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        addv(6'h38, 0, 1, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        addv(6'h2C, 0, 1, 32'h1234_5678, 4'b0010, 0, 0, 0);
        addv(6'h28, 1, 0, 0, 0, 1, 32'hFF, 0);
        addv(6'h24, 1, 0, 0, 0, 1, 32'hF, 0);
        addv(6'h38, 1, 0, 0, 0, 1, 0, 0);
        addv(6'h2C, 1, 0, 0, 0, 1, 0, 0);
        addv(6'h28, 0, 1, 32'hABCD_EF12, 4'b0001, 0, 0, 0);
        addv(6'h28, 1, 0, 0, 0, 1, 32'h12, 0);
        // Channel 0: PSC=0, ARR=4, IE+EN; CNT reads 0,1,2,3,4,0 and irq after 5 edges.
        addv(6'h04, 0, 1, 0, 4'hF, 0, 0, 0);
        addv(6'h08, 0, 1, 4, 4'hF, 0, 0, 0);
        addv(6'h00, 0, 1, 32'h5, 4'hF, 0, 0, 0);
        addv(6'h0C, 1, 0, 0, 0, 1, 0, 3'b000);
        addv(6'h0C, 1, 0, 0, 0, 1, 1, 3'b000);
        addv(6'h0C, 1, 0, 0, 0, 1, 2, 3'b000);
        addv(6'h0C, 1, 0, 0, 0, 1, 3, 3'b000);
        addv(6'h0C, 1, 0, 0, 0, 1, 4, 3'b001);
        addv(6'h0C, 1, 0, 0, 0, 1, 0, 3'b001);
        addv(6'h00, 0, 1, 32'h105, 4'hF, 1, 0, 3'b000);
        addv(6'h00, 1, 0, 0, 0, 1, 32'h005, 3'b000);
        addv(6'h0C, 1, 0, 0, 0, 1, 3, 3'b000);
        addv(6'h00, 1, 0, 0, 0, 1, 32'h005, 3'b001);
        addv(6'h00, 1, 0, 0, 0, 1, 32'h105, 3'b001);
        addv(6'h00, 0, 1, 32'h100, 4'hF, 1, 32'h105, 3'b000);
        addv(6'h0C, 1, 0, 0, 0, 1, 2, 3'b000);
        addv(6'h0C, 1, 0, 0, 0, 1, 2, 3'b000);

        bus.addr = 0; bus.rd_en = 0; bus.wr_en = 0; bus.wr_data = 0; bus.wr_strobe = 0;
        rst_n = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        check("reset_rd_data", bus.rd_data, 0);
        check("reset_irq", 32'(irq), 0);

        for (int i = 0; i < vq.size(); i++) begin
            do_cycle(vq[i].addr, vq[i].rd, vq[i].wr, vq[i].data, vq[i].strb);
            if (vq[i].chk) begin
                check($sformatf("vec%0d_rd", i), bus.rd_data, vq[i].exp_rd);
                check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vq[i].exp_irq));
            end
        end

        // Channel 1 one-shot: PSC=2, ARR=1 -> IF at EN edge +6, then stopped.
        do_cycle(6'h14, 0, 1, 2, 4'hF);
        do_cycle(6'h18, 0, 1, 1, 4'hF);
        do_cycle(6'h10, 0, 1, 32'h7, 4'hF);
        idle(5);
        check("oneshot_irq_before", 32'(irq[1]), 0);
        idle(1);
        check("oneshot_irq_at6", 32'(irq[1]), 1);
        do_cycle(6'h10, 1, 0, 0, 0);
        check("oneshot_ctrl", bus.rd_data, 32'h106);
        idle(20);
        do_cycle(6'h1C, 1, 0, 0, 0);
        check("oneshot_cnt_held", bus.rd_data, 0);

        // Channel 0: byte-1 IF clear on the wrap edge loses to the set; CNT write beats a tick.
        do_cycle(6'h08, 0, 1, 2, 4'hF);
        do_cycle(6'h0C, 0, 1, 0, 4'hF);
        do_cycle(6'h00, 0, 1, 32'h5, 4'hF);
        idle(2);
        do_cycle(6'h00, 0, 1, 32'h100, 4'b0010);
        check("setclr_irq", 32'(irq[0]), 1);
        do_cycle(6'h00, 1, 0, 0, 0);
        check("setclr_ctrl", bus.rd_data, 32'h105);
        do_cycle(6'h00, 0, 1, 32'h100, 4'b0010);
        check("partial_clr_irq", 32'(irq[0]), 0);
        do_cycle(6'h00, 1, 0, 0, 0);
        check("partial_clr_keeps_en", bus.rd_data, 32'h005);
        do_cycle(6'h0C, 0, 1, 7, 4'hF);
        do_cycle(6'h0C, 1, 0, 0, 0);
        check("cnt_write_wins", bus.rd_data, 7);
        do_cycle(6'h00, 0, 1, 32'h100, 4'hF);

        // Channel 2: ARR=3 with CNT=10 counts through 255, silent wrap, then IF at next ARR.
        do_cycle(6'h24, 0, 1, 0, 4'hF);
        do_cycle(6'h28, 0, 1, 3, 4'hF);
        do_cycle(6'h2C, 0, 1, 0, 4'hF);
        do_cycle(6'h20, 0, 1, 32'h5, 4'hF);
        do_cycle(6'h2C, 0, 1, 10, 4'hF);
        do_cycle(6'h20, 0, 1, 32'h105, 4'hF);
        idle(244);
        do_cycle(6'h2C, 1, 0, 0, 0);
        check("wrap_cnt_max", bus.rd_data, 255);
        check("wrap_no_irq", 32'(irq[2]), 0);
        idle(3);
        check("wrap_no_irq_at3", 32'(irq[2]), 0);
        idle(1);
        check("wrap_irq_after", 32'(irq[2]), 1);
        do_cycle(6'h2C, 1, 0, 0, 0);
        check("wrap_cnt_zero", bus.rd_data, 0);
        do_cycle(6'h20, 0, 1, 32'h100, 4'hF);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            logic [5:0]  a = 6'($urandom_range(0, 63));
            bit          rd = 1'($urandom_range(0, 1));
            bit          wr = ($urandom_range(0, 3) == 0);
            logic [31:0] d = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 7));
            logic [3:0]  s = $urandom_range(0, 1) ? 4'hF : 4'($urandom_range(0, 15));
            do_cycle(a, rd, wr, d, s);
            check("rand_rd", bus.rd_data, m_rd);
            check("rand_irq", 32'(irq), 32'(m_irq()));
        end

        // Asynchronous reset while channel 0 holds irq high.
        do_cycle(6'h04, 0, 1, 0, 4'hF);
        do_cycle(6'h08, 0, 1, 0, 4'hF);
        do_cycle(6'h0C, 0, 1, 0, 4'hF);
        do_cycle(6'h00, 0, 1, 32'h5, 4'hF);
        idle(1);
        check("pre_reset_irq", 32'(irq[0]), 1);
        #2 rst_n = 0;
        #1 check("async_reset_irq", 32'(irq), 0);
        m_reset();
        @(posedge clk);
        #1 rst_n = 1;
        check("async_reset_rd", bus.rd_data, 0);
        for (int i = 0; i < 16; i++) begin
            do_cycle(6'(4 * i), 1, 0, 0, 0);
            check($sformatf("post_reset_rd_%0h", 4 * i), bus.rd_data, 0);
        end
        check("post_reset_irq", 32'(irq), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gptim_mc.md
# gptim_mc

Multi-channel general-purpose timer peripheral. It generalises the fixed two-timer TIM0/TIM1 arrangement into one block with a parametrised channel count and counter width. Each channel has a per-channel prescaler, auto-reload, continuous or one-shot mode, and a write-1-to-clear interrupt flag. It sits on the core's memory-mapped peripheral bus and drives one interrupt line per channel into the platform interrupt CSR bits (TRAP_CODE_TIM0 upward).

## Interface
- CHANNELS, 2: number of independent timer channels, 1..8.
- WIDTH, 32: counter/auto-reload width, 8..32.
- PRESC_WIDTH, 16: prescaler width, 1..32.
- ADDR_WIDTH, 4+$clog2(CHANNELS) (minimum 4): byte address bits; each channel owns a 16-byte window.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored
- rd_en  in  1  read request
- wr_en  in  1  write request
- wr_data  in  32  write data
- wr_strobe  in  4  byte enables for wr_data
- rd_data  out  32  read data, registered
- irq  out  CHANNELS  per-channel interrupt, equal to IF & IE

## Operation
- Channel n window starts at n*16. Register offsets:
  - 0x0 CTRL: bit0 EN, bit1 ONESHOT, bit2 IE, bit8 IF. IF is read-only and cleared by writing 1 to bit8. Other bits read 0.
  - 0x4 PSC: prescale value.
  - 0x8 ARR: auto-reload value.
  - 0xC CNT: current count, R/W.
- Register bits above WIDTH or PSC_WIDTH are ignored on write and read 0. Addresses beyond CHANNELS*16 read 0 and ignore writes.
- Reset values: all registers 0, psc_cnt 0, rd_data 0, irq 0.
- Per-channel states:
  - IDLE (EN=0): CNT and psc_cnt hold.
  - RUN (EN=1): each cycle, if psc_cnt==PSC, psc_cnt←0 and a tick is issued; otherwise psc_cnt+1.
- On tick:
  - If CNT==ARR: CNT←0, IF←1, and if ONESHOT then EN←0 (RUN→IDLE).
  - Otherwise CNT←CNT+1.
- Clearing EN by write resets psc_cnt to 0. A write to PSC also resets psc_cnt to 0.
- Period is (PSC+1)*(ARR+1) cycles. ARR=0 overflows on every tick. PSC=0 ticks every cycle.
- Simultaneous events, same cycle:
  - Software write to CNT and a tick: the write wins; the tick is lost and no IF is set by it.
  - IF set and IF W1C clear: the set wins; IF stays 1.
  - One-shot auto-clear of EN and software write setting EN: the write wins; the channel keeps running.
  - Write to ARR below the current CNT: CNT counts up to the WIDTH maximum, wraps to 0 by modular +1 without setting IF, then continues to the new ARR.
- Byte strobes apply per register. A partial write to CTRL byte1 with bit8=1 clears IF without touching EN.
- rd_en and wr_en in the same cycle: the write commits, and the read returns the pre-write value.

## Timing
- Read latency is 1 cycle: rd_data is valid on the cycle after rd_en and holds until the next rd_en.
- Writes commit at the clock edge where wr_en is sampled.
- An EN write at edge t makes the first tick occur at edge t+PSC+1.
- IF and irq rise on the same edge where CNT wraps to 0. irq has no combinational path from the bus.
- Asynchronous reset mid-count: all state clears immediately, and irq deasserts without waiting for a clock edge.

## Test plan
- Reset, then read all windows -> rd_data=0 everywhere; irq=0.
- Ch0: PSC=0, ARR=4, IE=1, EN=1 -> CNT sequence 1,2,3,4,0. irq[0] rises 5 cycles after the EN edge and re-arms every 5 cycles. Writing CTRL=0x105 clears irq[0] for one period.
- Ch1: PSC=2, ARR=1, ONESHOT=1, EN=1 -> IF set at edge +6. EN reads 0 afterwards, and CNT stays 0 for 20 further cycles.
- Clear vs set: write IF=1 on the exact wrap cycle -> IF remains 1. Write CNT=7 on a tick cycle -> the next read returns 7.
- WIDTH=8, ARR=3, CNT=10 written while running -> CNT reaches 255, wraps to 0 with no IF, then IF is set at the next CNT==3 wrap.
- Assert rst_n low for 1 cycle mid-count with irq high -> irq drops asynchronously, and all registers read 0 afterwards.
